inst_encoder: RTL and testbench
===============================

# inst_encoder

Packs decoded instruction fields plus a 64-bit sign-extended immediate into a 32-bit RV64 instruction word for the I-type (load, ALU-immediate, JALR) and S-type (store) formats, i.e. the inverse of the immediate generator. It range-checks the immediate and buffers results in a 2-entry output FIFO with valid/ready handshakes. Each emitted word is tagged with a sequential instruction-memory word address, so the block can drive the instruction-memory loader and test benches.

## Interface
- ADDR_W, 8, width of the instruction-memory word address counter
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous flush: empties the FIFO, zeroes the address counter, err_range and drop_cnt
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready at a rising edge
- in_fmt  input  2  0=load (0000011), 1=ALU-imm (0010011), 2=JALR (1100111), 3=store (0100011)
- in_rd, in_rs1, in_rs2  input  5 each  register fields (in_rd ignored for store; in_rs2 ignored for I-type)
- in_funct3  input  3  funct3 field (forced to 000 for JALR)
- in_imm  input  64  sign-extended immediate
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head when out_valid & out_ready
- out_inst  output  32  encoded instruction at FIFO head
- out_addr  output  ADDR_W  word address assigned to the head entry
- err_range  output  1  sticky: some request was dropped for an out-of-range immediate
- drop_cnt  output  8  count of dropped requests, saturates at 255

## Operation
- I-type: inst = {imm[11:0], rs1, funct3, rd, opcode}.
- S-type: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- Range check: the request is legal iff in_imm[63:11] is all zeros or all ones (range -2048..2047).
- Legal accepted request: pushed with the current address counter value, then the counter increments by 1 and wraps modulo 2^ADDR_W.
- Illegal accepted request: not pushed; err_range is set and drop_cnt increments (saturating); the address counter is unchanged.
- FIFO: 2 entries, in order. in_ready = (count < 2), registered-state only, with no combinational path from out_ready. A push and a pop in the same cycle at count 1 leaves count 1.
- Illegal requests are accepted under the same in_ready rule, so a full FIFO also stalls them.
- clear takes priority over a same-cycle push or pop. A request presented during clear is consumed (in_ready may be high) and discarded, not counted.
- Reset or clear mid-stream discards all FIFO contents with no partial output.

## Timing
- Reset values: out_valid=0, out_inst=0, out_addr=0, in_ready=1, err_range=0, drop_cnt=0, address counter=0, FIFO empty.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1). Encoding is registered at push.
- out_inst and out_addr are held stable while out_valid=1 and out_ready=0.
- Throughput: 1 word per cycle when out_ready is held high.
- err_range and drop_cnt update at the accepting edge.
- clear takes effect at the edge where it is sampled high; the following cycle shows out_valid=0 and in_ready=1.
- Outputs are deasserted asynchronously on rst_n falling; operation resumes at the first edge after rst_n rises.

## Test plan
- ALU-imm: rd=5, rs1=0, funct3=0, imm=64'hFFFF_FFFF_FFFF_FFFF, out_ready=1 -> next cycle out_valid=1, out_inst=32'hFFF00293, out_addr=0.
- Store: rs1=1, rs2=2, funct3=3, imm=8 -> out_inst=32'h0020B423. JALR: rd=1, rs1=6, funct3=5, imm=0 -> out_inst=32'h000300E7 (funct3 forced to 0).
- Out-of-range: ALU request with imm=2048 -> no out_valid, err_range=1, drop_cnt=1. The next legal request gets out_addr unchanged; 256 illegal requests hold drop_cnt at 255.
- Backpressure: out_ready=0, three back-to-back legal requests -> first two accepted, in_ready=0 with the third held. Then out_ready=1 -> words emitted in order at addresses 0, 1, 2 with no loss or duplication.
- Wrap: ADDR_W=2, five legal requests -> out_addr sequence 0, 1, 2, 3, 0.
- Clear/reset: two entries queued, then pulse clear with in_valid=1 -> next cycle out_valid=0, counter, err_range and drop_cnt all 0. The next request gets addr 0. Asserting rst_n low mid-stream gives the same result asynchronously.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV64 I-type / S-type fields and a sign-extended
// immediate into a 32-bit instruction word. Out-of-range immediates are
// dropped and counted. Legal words are queued in a 2-entry FIFO, each tagged
// with a sequential instruction-memory word address.
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_range,
    output logic [7:0]        drop_cnt
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Build the instruction word for one request; JALR always uses funct3 000.
    function automatic logic [31:0] f_encode(
        input logic [1:0]  fmt,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [11:0] imm12
    );
        logic [31:0] word;
        case (fmt)
            2'd0:    word = {imm12, rs1, funct3, rd, OP_LOAD};
            2'd1:    word = {imm12, rs1, funct3, rd, OP_ALUI};
            2'd2:    word = {imm12, rs1, 3'b000, rd, OP_JALR};
            2'd3:    word = {imm12[11:5], rs2, rs1, funct3, imm12[4:0], OP_STORE};
            default: word = 32'd0;
        endcase
        return word;
    endfunction

    // The immediate fits in 12 signed bits iff bits 63..11 are all equal.
    function automatic logic f_imm_legal(input logic [63:0] imm);
        return (&imm[63:11]) | ~(|imm[63:11]);
    endfunction

    // FIFO storage and bookkeeping
    logic [31:0]       r_inst0, r_inst1;
    logic [ADDR_W-1:0] r_addr0, r_addr1;
    logic              r_wptr, r_rptr;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic              r_err;
    logic [7:0]        r_drop;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_addr;

    // Next-state values
    logic              w_accept, w_legal, w_push, w_drop, w_pop;
    logic [31:0]       w_enc;
    logic [31:0]       w_inst0_next, w_inst1_next;
    logic [ADDR_W-1:0] w_addr0_next, w_addr1_next;
    logic              w_wptr_next, w_rptr_next;
    logic [1:0]        w_count_next;
    logic [ADDR_W-1:0] w_addr_cnt_next;
    logic              w_err_next;
    logic [7:0]        w_drop_next;

    // Handshake decode, FIFO update and error bookkeeping; clear overrides all.
    always_comb begin
        w_accept        = in_valid & r_in_ready;
        w_legal         = f_imm_legal(in_imm);
        w_push          = w_accept & w_legal & ~clear;
        w_drop          = w_accept & ~w_legal & ~clear;
        w_pop           = r_out_valid & out_ready & ~clear;
        w_enc           = f_encode(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm[11:0]);
        w_inst0_next    = r_inst0;
        w_inst1_next    = r_inst1;
        w_addr0_next    = r_addr0;
        w_addr1_next    = r_addr1;
        w_wptr_next     = r_wptr;
        w_rptr_next     = r_rptr;
        w_count_next    = r_count;
        w_addr_cnt_next = r_addr_cnt;
        w_err_next      = r_err;
        w_drop_next     = r_drop;

        if (clear) begin
            w_wptr_next     = 1'b0;
            w_rptr_next     = 1'b0;
            w_count_next    = 2'd0;
            w_addr_cnt_next = {ADDR_W{1'b0}};
            w_err_next      = 1'b0;
            w_drop_next     = 8'd0;
        end else begin
            if (w_push) begin
                if (r_wptr) begin
                    w_inst1_next = w_enc;
                    w_addr1_next = r_addr_cnt;
                end else begin
                    w_inst0_next = w_enc;
                    w_addr0_next = r_addr_cnt;
                end
                w_wptr_next     = ~r_wptr;
                w_addr_cnt_next = r_addr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                w_wptr_next     = r_wptr;
            end

            if (w_pop) begin
                w_rptr_next = ~r_rptr;
            end else begin
                w_rptr_next = r_rptr;
            end

            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 2'd1;
                2'b01:   w_count_next = r_count - 2'd1;
                default: w_count_next = r_count;
            endcase

            if (w_drop) begin
                w_err_next = 1'b1;
                if (r_drop != 8'd255) begin
                    w_drop_next = r_drop + 8'd1;
                end else begin
                    w_drop_next = r_drop;
                end
            end else begin
                w_err_next  = r_err;
                w_drop_next = r_drop;
            end
        end
    end

    // State registers; head-of-FIFO outputs are registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst0     <= 32'd0;
            r_inst1     <= 32'd0;
            r_addr0     <= {ADDR_W{1'b0}};
            r_addr1     <= {ADDR_W{1'b0}};
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_addr_cnt  <= {ADDR_W{1'b0}};
            r_err       <= 1'b0;
            r_drop      <= 8'd0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_inst  <= 32'd0;
            r_out_addr  <= {ADDR_W{1'b0}};
        end else begin
            r_inst0     <= w_inst0_next;
            r_inst1     <= w_inst1_next;
            r_addr0     <= w_addr0_next;
            r_addr1     <= w_addr1_next;
            r_wptr      <= w_wptr_next;
            r_rptr      <= w_rptr_next;
            r_count     <= w_count_next;
            r_addr_cnt  <= w_addr_cnt_next;
            r_err       <= w_err_next;
            r_drop      <= w_drop_next;
            r_out_valid <= (w_count_next != 2'd0);
            r_in_ready  <= (w_count_next != 2'd2);
            r_out_inst  <= w_rptr_next ? w_inst1_next : w_inst0_next;
            r_out_addr  <= w_rptr_next ? w_addr1_next : w_addr0_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_addr  = r_out_addr;
    assign err_range = r_err;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder. A queue-based reference model tracks
// the expected FIFO contents, address counter and drop statistics; a second
// instance with ADDR_W=2 shares the stimulus to exercise address wrap.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_fmt = 2'd0;
    logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [63:0] in_imm = 64'd0;

    logic        in_ready, out_valid, err_range;
    logic [31:0] out_inst;
    logic [7:0]  out_addr, drop_cnt;
    logic        d2_in_ready, d2_out_valid, d2_err;
    logic [31:0] d2_inst;
    logic [1:0]  d2_addr;
    logic [7:0]  d2_drop;

    inst_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .err_range(err_range), .drop_cnt(drop_cnt)
    );

    inst_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_imm(in_imm), .out_valid(d2_out_valid), .out_ready(out_ready), .out_inst(d2_inst),
        .out_addr(d2_addr), .err_range(d2_err), .drop_cnt(d2_drop)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] inst; int addr; } ent_t;
    ent_t m_q[$];
    int   m_addr = 0;
    bit   m_err = 1'b0;
    int   m_drop = 0;
    bit   m_acc = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference encoding computed with plain arithmetic on field values.
    function automatic logic [31:0] m_encode(int fmt, int rd, int rs1, int rs2, int f3, longint imm);
        longint lo, op, w;
        lo = imm & 64'sd4095;
        op = (fmt == 0) ? 3 : (fmt == 1) ? 19 : (fmt == 2) ? 103 : 35;
        if (fmt == 2) f3 = 0;
        if (fmt == 3)
            w = ((lo >> 5) << 25) + (longint'(rs2) << 20) + (longint'(rs1) << 15)
              + (longint'(f3) << 12) + ((lo & 31) << 7) + op;
        else
            w = (lo << 20) + (longint'(rs1) << 15) + (longint'(f3) << 12) + (longint'(rd) << 7) + op;
        return 32'(w);
    endfunction

    function automatic bit m_legal(logic [63:0] imm);
        longint s;
        s = $signed(imm);
        return (s >= -2048) && (s <= 2047);
    endfunction

    function automatic longint rand_imm(bit legal_only);
        int sel;
        sel = legal_only ? 9 : $urandom_range(0, 9);
        case (sel)
            0:       return 2047;
            1:       return -2048;
            2:       return 2048;
            3:       return -2049;
            4:       return $signed({$urandom, $urandom});
            default: return longint'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    task automatic set_req(int fmt, int rd, int rs1, int rs2, int f3, longint imm);
        in_valid = 1'b1; in_fmt = 2'(fmt); in_rd = 5'(rd); in_rs1 = 5'(rs1);
        in_rs2 = 5'(rs2); in_funct3 = 3'(f3); in_imm = 64'(imm);
    endtask

    task automatic set_rand_req(bit legal_only);
        set_req($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 7), rand_imm(legal_only));
    endtask

    // Advance the model by one clock edge from the current inputs, then step the clock.
    task automatic tick();
        bit pop;
        ent_t e;
        m_acc = in_valid && (m_q.size() < 2);
        if (clear) begin
            m_q.delete(); m_addr = 0; m_err = 1'b0; m_drop = 0;
        end else begin
            pop = (m_q.size() > 0) && out_ready;
            if (pop) m_q.delete(0);
            if (m_acc) begin
                if (m_legal(in_imm)) begin
                    e.inst = m_encode(int'(in_fmt), int'(in_rd), int'(in_rs1), int'(in_rs2),
                                      int'(in_funct3), $signed(in_imm));
                    e.addr = m_addr;
                    m_q.push_back(e);
                    m_addr++;
                end else begin
                    m_err = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        n_checks++; if (out_inst !== 32'd0 || out_addr !== 8'd0) begin n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", out_inst, out_addr); end
        n_checks++; if (err_range !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err got=%0h/%0d exp=0/0", err_range, drop_cnt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        set_req(1, 5, 0, 0, 0, -1);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'hFFF00293 || out_addr !== 8'd0) begin
            n_fail++; $display("FAIL alu_imm got=%0h/%h/%0d exp=1/fff00293/0", out_valid, out_inst, out_addr); end
        set_req(3, 0, 1, 2, 3, 8);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0020B423 || out_addr !== 8'd1) begin
            n_fail++; $display("FAIL store got=%0h/%h/%0d exp=1/0020b423/1", out_valid, out_inst, out_addr); end
        set_req(2, 1, 6, 0, 5, 0);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h000300E7 || out_addr !== 8'd2) begin
            n_fail++; $display("FAIL jalr got=%0h/%h/%0d exp=1/000300e7/2", out_valid, out_inst, out_addr); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0h exp=0", out_valid); end
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        set_req(1, 3, 4, 0, 0, 2048);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || err_range !== 1'b1 || drop_cnt !== 8'd1) begin
            n_fail++; $display("FAIL range_drop got=%0h/%0h/%0d exp=0/1/1", out_valid, err_range, drop_cnt); end
        set_req(0, 7, 8, 0, 2, 100);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 8'd3 || out_inst !== m_encode(0, 7, 8, 0, 2, 100)) begin
            n_fail++; $display("FAIL range_addr_hold got=%0h/%0d/%h exp=1/3/%h", out_valid, out_addr, out_inst, m_encode(0, 7, 8, 0, 2, 100)); end
        set_req(1, 3, 4, 0, 0, -2049);
        repeat (256) tick();
        in_valid = 1'b0;
        n_checks++; if (drop_cnt !== 8'd255 || err_range !== 1'b1) begin
            n_fail++; $display("FAIL drop_saturate got=%0d/%0h exp=255/1", drop_cnt, err_range); end
        tick();
    endtask

    task automatic test_clear();
        clear = 1'b1; in_valid = 1'b0;
        tick();
        clear = 1'b0;
        n_checks++; if (err_range !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL clear_stats got=%0h/%0d exp=0/0", err_range, drop_cnt); end
        out_ready = 1'b0;
        set_req(0, 1, 1, 0, 0, 5000);
        tick();
        set_rand_req(1'b1); tick();
        set_rand_req(1'b1); tick();
        n_checks++; if (in_ready !== 1'b0 || err_range !== 1'b1) begin
            n_fail++; $display("FAIL clear_prefill got=%0h/%0h exp=0/1", in_ready, err_range); end
        clear = 1'b1;
        set_rand_req(1'b1);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_range !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL clear_flush got=%0h/%0h/%0h/%0d exp=0/1/0/0", out_valid, in_ready, err_range, drop_cnt); end
        set_req(1, 2, 3, 0, 1, -7);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 8'd0 || out_inst !== m_encode(1, 2, 3, 0, 1, -7)) begin
            n_fail++; $display("FAIL clear_addr0 got=%0h/%0d/%h exp=1/0/%h", out_valid, out_addr, out_inst, m_encode(1, 2, 3, 0, 1, -7)); end
    endtask

    task automatic test_backpressure();
        int f[3], rd[3], r1[3], r2[3], f3[3];
        longint im[3];
        logic [31:0] exp_i[3];
        logic [31:0] seen_i[$];
        int seen_a[$];
        int k, cyc;
        clear = 1'b1; in_valid = 1'b0;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f[i] = $urandom_range(0, 3); rd[i] = $urandom_range(0, 31); r1[i] = $urandom_range(0, 31);
            r2[i] = $urandom_range(0, 31); f3[i] = $urandom_range(0, 7); im[i] = rand_imm(1'b1);
            exp_i[i] = m_encode(f[i], rd[i], r1[i], r2[i], f3[i], im[i]);
        end
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            set_req(f[k], rd[k], r1[k], r2[k], f3[k], im[k]);
            tick();
            if (m_acc) k++;
            n_checks++; if (out_valid !== 1'b1 || out_inst !== exp_i[0] || out_addr !== 8'd0) begin
                n_fail++; $display("FAIL bp_hold got=%0h/%h/%0d exp=1/%h/0", out_valid, out_inst, out_addr, exp_i[0]); end
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got=%0h exp=0", in_ready); end
        out_ready = 1'b1;
        cyc = 0;
        while (seen_a.size() < 3 && cyc < 20) begin
            if (k < 3) set_req(f[k], rd[k], r1[k], r2[k], f3[k], im[k]);
            else in_valid = 1'b0;
            if (out_valid) begin seen_a.push_back(int'(out_addr)); seen_i.push_back(out_inst); end
            tick();
            if (m_acc && k < 3) k++;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++; if (seen_a.size() != 3) begin n_fail++; $display("FAIL bp_count got=%0d exp=3", seen_a.size()); end
        for (int i = 0; i < seen_a.size() && i < 3; i++) begin
            n_checks++; if (seen_a[i] != i || seen_i[i] !== exp_i[i]) begin
                n_fail++; $display("FAIL bp_order[%0d] got=%0d/%h exp=%0d/%h", i, seen_a[i], seen_i[i], i, exp_i[i]); end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%0h exp=0", out_valid); end
    endtask

    task automatic test_wrap();
        int exp_w[5] = '{0, 1, 2, 3, 0};
        clear = 1'b1; in_valid = 1'b0;
        tick();
        clear = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_rand_req(1'b1);
            tick();
            n_checks++; if (d2_out_valid !== 1'b1 || d2_addr !== 2'(exp_w[i]) || out_addr !== 8'(i)) begin
                n_fail++; $display("FAIL wrap[%0d] got=%0d/%0d exp=%0d/%0d", i, d2_addr, out_addr, exp_w[i], i); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_req(1, 1, 1, 0, 0, 9999); tick();
        set_rand_req(1'b1); tick();
        set_rand_req(1'b1); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_q.delete(); m_addr = 0; m_err = 1'b0; m_drop = 0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'd0 || err_range !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL async_reset got=%0h/%0h/%h/%0h/%0d exp=0/1/0/0/0", out_valid, in_ready, out_inst, err_range, drop_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(3, 0, 9, 10, 2, -16);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 8'd0 || out_inst !== m_encode(3, 0, 9, 10, 2, -16)) begin
            n_fail++; $display("FAIL reset_addr0 got=%0h/%0d/%h exp=1/0/%h", out_valid, out_addr, out_inst, m_encode(3, 0, 9, 10, 2, -16)); end
    endtask

    task automatic test_random();
        logic [31:0] ei;
        int ea;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 7) set_rand_req(1'b0); else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 6);
            clear = ($urandom_range(0, 99) < 3);
            tick();
            n_checks++; if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2)
                            || d2_out_valid !== out_valid || d2_in_ready !== in_ready) begin
                n_fail++; $display("FAIL rnd_flags c=%0d got=%0h/%0h exp=%0h/%0h", c, out_valid, in_ready, m_q.size() > 0, m_q.size() < 2); end
            n_checks++; if (err_range !== m_err || drop_cnt !== 8'(m_drop) || d2_err !== m_err || d2_drop !== 8'(m_drop)) begin
                n_fail++; $display("FAIL rnd_err c=%0d got=%0h/%0d exp=%0h/%0d", c, err_range, drop_cnt, m_err, m_drop); end
            if (m_q.size() > 0) begin
                ei = m_q[0].inst; ea = m_q[0].addr;
                n_checks++; if (out_inst !== ei || out_addr !== 8'(ea) || d2_inst !== ei || d2_addr !== 2'(ea)) begin
                    n_fail++; $display("FAIL rnd_head c=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", c, out_inst, out_addr, d2_addr, ei, ea % 256, ea % 4); end
            end
        end
        clear = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_range();
        test_clear();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
